// File: rtl/sb_pkg.sv
// Package: sb_pkg
// Shared constants, state encodings and the CRC helper for the USB4
// sideband receive path (sb_transaction_rx and sb_symbol_deser).
//   DLE / STX_CMD / STX_RSP / ETX : sideband framing symbols
//   sb_rx_state_e                 : transaction parser states
//   sb_deser_state_e              : symbol deserialiser states
//   crc16_8005                    : one-byte CRC-16 update (poly 0x8005, MSB first)
package sb_pkg;

  localparam logic [7:0] DLE     = 8'hFE;
  localparam logic [7:0] STX_CMD = 8'h05;
  localparam logic [7:0] STX_RSP = 8'h04;
  localparam logic [7:0] ETX     = 8'h40;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GOT_DLE = 3'd1,
    ST_LT_CMP  = 3'd2,
    ST_AT_BODY = 3'd3,
    ST_AT_DLE  = 3'd4
  } sb_rx_state_e;

  typedef enum logic [1:0] {
    DS_IDLE      = 2'd0,
    DS_DATA      = 2'd1,
    DS_WAIT_HIGH = 2'd2
  } sb_deser_state_e;

  // Bit-serial update: each data bit (MSB first) is folded into the CRC MSB.
  function automatic logic [15:0] crc16_8005(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      if (c[15] ^ data[i]) begin
        c = {c[14:0], 1'b0} ^ 16'h8005;
      end else begin
        c = {c[14:0], 1'b0};
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/sb_symbol_deser.sv
// Module: sb_symbol_deser
// Synchronises sbrx and deserialises 10-bit sideband symbols
// (start=0, d0..d7 LSB first, stop=1), one bit per sb_clk cycle.
// Ports:
//   sb_clk, rst (sync, active high), enable (0 = held idle, partial symbol dropped)
//   sbrx       serial input, idle high
//   sym_valid  1-cycle pulse the cycle after a good stop bit was sampled
//   sym_data   received byte, valid with sym_valid
//   frame_err  1-cycle pulse when the stop bit was sampled 0
module sb_symbol_deser
  import sb_pkg::*;
#(
  parameter int SYNC_STG = 2
) (
  input  logic       sb_clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       sbrx,
  output logic       sym_valid,
  output logic [7:0] sym_data,
  output logic       frame_err
);

  logic [SYNC_STG-1:0] sync_r;
  logic                rx_s;
  sb_deser_state_e     state_r, state_nxt;
  logic [3:0]          cnt_r, cnt_nxt;
  logic [7:0]          shift_r, shift_nxt;
  logic [7:0]          data_r, data_nxt;
  logic                valid_r, valid_nxt;
  logic                ferr_r, ferr_nxt;

  assign rx_s      = sync_r[SYNC_STG-1];
  assign sym_valid = valid_r;
  assign sym_data  = data_r;
  assign frame_err = ferr_r;

  // Input synchroniser; resets to the idle-high line level.
  always_ff @(posedge sb_clk) begin
    if (rst) begin
      sync_r <= {SYNC_STG{1'b1}};
    end else begin
      sync_r <= {sync_r[SYNC_STG-2:0], sbrx};
    end
  end

  // Next-state logic: the start bit is consumed in DS_IDLE (count 0),
  // data bits at counts 1..8, stop bit at count 9.
  always_comb begin
    state_nxt = state_r;
    cnt_nxt   = cnt_r;
    shift_nxt = shift_r;
    data_nxt  = data_r;
    valid_nxt = 1'b0;
    ferr_nxt  = 1'b0;
    case (state_r)
      DS_IDLE: begin
        if (!rx_s) begin
          state_nxt = DS_DATA;
          cnt_nxt   = 4'd1;
        end else begin
          state_nxt = DS_IDLE;
        end
      end
      DS_DATA: begin
        if (cnt_r == 4'd9) begin
          cnt_nxt = 4'd0;
          if (rx_s) begin
            valid_nxt = 1'b1;
            data_nxt  = shift_r;
            state_nxt = DS_IDLE;
          end else begin
            // Bad stop: wait for the line to return high before re-arming.
            ferr_nxt  = 1'b1;
            state_nxt = DS_WAIT_HIGH;
          end
        end else begin
          shift_nxt = {rx_s, shift_r[7:1]};
          cnt_nxt   = cnt_r + 4'd1;
        end
      end
      DS_WAIT_HIGH: begin
        if (rx_s) begin
          state_nxt = DS_IDLE;
        end else begin
          state_nxt = DS_WAIT_HIGH;
        end
      end
      default: begin
        state_nxt = DS_IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Deserialiser registers; disable drops any partial symbol.
  always_ff @(posedge sb_clk) begin
    if (rst) begin
      state_r <= DS_IDLE;
      cnt_r   <= 4'd0;
      shift_r <= 8'h00;
      data_r  <= 8'h00;
      valid_r <= 1'b0;
      ferr_r  <= 1'b0;
    end else if (!enable) begin
      state_r <= DS_IDLE;
      cnt_r   <= 4'd0;
      shift_r <= 8'h00;
      valid_r <= 1'b0;
      ferr_r  <= 1'b0;
    end else begin
      state_r <= state_nxt;
      cnt_r   <= cnt_nxt;
      shift_r <= shift_nxt;
      data_r  <= data_nxt;
      valid_r <= valid_nxt;
      ferr_r  <= ferr_nxt;
    end
  end

endmodule

// File: rtl/sb_transaction_rx.sv
// Module: sb_transaction_rx
// USB4 sideband receive path: deserialises sbrx and parses LT and AT
// transactions for the lane-init FSM.
// Optional feature macro: SB_RX_CRC_CHECK_EN (defined = AT CRC-16 checked
// and crc_err driven; undefined = no CRC logic, crc_err tied 0).
// Ports:
//   sb_clk, rst (sync, active high), enable (0 = parser/deser forced idle)
//   sbrx                       serial sideband input, idle high
//   lt_valid / lt_lse          LT received pulse / its LSE byte (held)
//   at_valid / at_is_rsp       AT complete pulse / STX was STX_RSP (held)
//   at_len / at_payload        AT payload byte count and bytes, byte i at [8i+7:8i]
//   crc_err                    pulse with at_valid on CRC mismatch
//   frame_err / proto_err      stop-bit error / illegal sequence or overflow pulses
//   busy                       parser not idle
module sb_transaction_rx
  import sb_pkg::*;
#(
  parameter int MAX_BYTES = 16,
  parameter int SYNC_STG  = 2
) (
  input  logic                           sb_clk,
  input  logic                           rst,
  input  logic                           sbrx,
  input  logic                           enable,
  output logic                           lt_valid,
  output logic [7:0]                     lt_lse,
  output logic                           at_valid,
  output logic                           at_is_rsp,
  output logic [$clog2(MAX_BYTES+1)-1:0] at_len,
  output logic [8*MAX_BYTES-1:0]         at_payload,
  output logic                           crc_err,
  output logic                           frame_err,
  output logic                           proto_err,
  output logic                           busy
);

  localparam int LEN_W = $clog2(MAX_BYTES + 1);
  localparam int RCV_W = $clog2(MAX_BYTES + 3);

  logic       sym_valid_s;
  logic [7:0] sym_data_s;
  logic       frame_err_s;

  sb_symbol_deser #(.SYNC_STG(SYNC_STG)) u_deser (
    .sb_clk    (sb_clk),
    .rst       (rst),
    .enable    (enable),
    .sbrx      (sbrx),
    .sym_valid (sym_valid_s),
    .sym_data  (sym_data_s),
    .frame_err (frame_err_s)
  );

  sb_rx_state_e           state_r, state_nxt;
  logic [7:0]             lse_r, lse_nxt;
  logic                   is_rsp_r, is_rsp_nxt;
  // Two-byte delay line holds back the trailing CRC bytes from the buffer.
  logic [7:0]             dl0_r, dl0_nxt, dl1_r, dl1_nxt;
  logic [1:0]             dl_cnt_r, dl_cnt_nxt;
  logic [RCV_W-1:0]       rcv_cnt_r, rcv_cnt_nxt;
  logic [8*MAX_BYTES-1:0] buf_r, buf_nxt;
  logic [LEN_W-1:0]       buf_cnt_r, buf_cnt_nxt;
  logic                   append_s;
  logic [7:0]             append_byte_s;
  logic                   lt_valid_r, lt_valid_nxt;
  logic [7:0]             lt_lse_r, lt_lse_nxt;
  logic                   at_valid_r, at_valid_nxt;
  logic                   at_is_rsp_r, at_is_rsp_nxt;
  logic [LEN_W-1:0]       at_len_r, at_len_nxt;
  logic [8*MAX_BYTES-1:0] at_payload_r, at_payload_nxt;
  logic                   proto_err_r, proto_err_nxt;
  logic                   busy_r;
`ifdef SB_RX_CRC_CHECK_EN
  logic [15:0]            crc_r, crc_nxt;
  logic                   crc_err_r, crc_err_nxt;
`endif

  assign lt_valid   = lt_valid_r;
  assign lt_lse     = lt_lse_r;
  assign at_valid   = at_valid_r;
  assign at_is_rsp  = at_is_rsp_r;
  assign at_len     = at_len_r;
  assign at_payload = at_payload_r;
  assign frame_err  = frame_err_s;
  assign proto_err  = proto_err_r;
  assign busy       = busy_r;
`ifdef SB_RX_CRC_CHECK_EN
  assign crc_err    = crc_err_r;
`else
  assign crc_err    = 1'b0;
`endif

  // Parser next-state, delay line, buffer and CRC update on each symbol.
  always_comb begin
    state_nxt      = state_r;
    lse_nxt        = lse_r;
    is_rsp_nxt     = is_rsp_r;
    dl0_nxt        = dl0_r;
    dl1_nxt        = dl1_r;
    dl_cnt_nxt     = dl_cnt_r;
    rcv_cnt_nxt    = rcv_cnt_r;
    buf_nxt        = buf_r;
    buf_cnt_nxt    = buf_cnt_r;
    append_s       = 1'b0;
    append_byte_s  = 8'h00;
    lt_valid_nxt   = 1'b0;
    lt_lse_nxt     = lt_lse_r;
    at_valid_nxt   = 1'b0;
    at_is_rsp_nxt  = at_is_rsp_r;
    at_len_nxt     = at_len_r;
    at_payload_nxt = at_payload_r;
    proto_err_nxt  = 1'b0;
`ifdef SB_RX_CRC_CHECK_EN
    crc_nxt        = crc_r;
    crc_err_nxt    = 1'b0;
`endif

    if (frame_err_s) begin
      state_nxt = ST_IDLE;
    end else if (sym_valid_s) begin
      case (state_r)
        ST_IDLE: begin
          if (sym_data_s == DLE) begin
            state_nxt = ST_GOT_DLE;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
        ST_GOT_DLE: begin
          if (sym_data_s == STX_CMD || sym_data_s == STX_RSP) begin
            state_nxt   = ST_AT_BODY;
            is_rsp_nxt  = (sym_data_s == STX_RSP);
            buf_nxt     = '0;
            buf_cnt_nxt = '0;
            dl_cnt_nxt  = 2'd0;
            rcv_cnt_nxt = '0;
`ifdef SB_RX_CRC_CHECK_EN
            crc_nxt     = crc16_8005(16'hFFFF, sym_data_s);
`endif
          end else if (sym_data_s == DLE) begin
            state_nxt = ST_GOT_DLE;
          end else begin
            lse_nxt   = sym_data_s;
            state_nxt = ST_LT_CMP;
          end
        end
        ST_LT_CMP: begin
          state_nxt = ST_IDLE;
          if (sym_data_s == ~lse_r) begin
            lt_valid_nxt = 1'b1;
            lt_lse_nxt   = lse_r;
          end else begin
            proto_err_nxt = 1'b1;
          end
        end
        ST_AT_BODY: begin
          if (sym_data_s == DLE) begin
            state_nxt = ST_AT_DLE;
          end else begin
            append_s      = 1'b1;
            append_byte_s = sym_data_s;
          end
        end
        ST_AT_DLE: begin
          if (sym_data_s == DLE) begin
            state_nxt     = ST_AT_BODY;
            append_s      = 1'b1;
            append_byte_s = DLE;
          end else if (sym_data_s == ETX) begin
            state_nxt = ST_IDLE;
            if (rcv_cnt_r < RCV_W'(2)) begin
              proto_err_nxt = 1'b1;
            end else begin
              at_valid_nxt   = 1'b1;
              at_is_rsp_nxt  = is_rsp_r;
              at_len_nxt     = buf_cnt_r;
              at_payload_nxt = buf_r;
`ifdef SB_RX_CRC_CHECK_EN
              // crc_lo arrived first, so it sits in the older slot.
              crc_err_nxt    = (crc_r != {dl0_r, dl1_r});
`endif
            end
          end else begin
            proto_err_nxt = 1'b1;
            state_nxt     = ST_IDLE;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end else begin
      state_nxt = state_r;
    end

    if (append_s) begin
      if (rcv_cnt_r == RCV_W'(MAX_BYTES + 2)) begin
        proto_err_nxt = 1'b1;
        state_nxt     = ST_IDLE;
      end else begin
        if (dl_cnt_r == 2'd2) begin
          // Oldest byte leaves the delay line: it is payload, not CRC.
          for (int i = 0; i < MAX_BYTES; i++) begin
            if (LEN_W'(i) == buf_cnt_r) begin
              buf_nxt[8*i +: 8] = dl1_r;
            end else begin
              buf_nxt[8*i +: 8] = buf_r[8*i +: 8];
            end
          end
          buf_cnt_nxt = buf_cnt_r + LEN_W'(1);
`ifdef SB_RX_CRC_CHECK_EN
          crc_nxt     = crc16_8005(crc_r, dl1_r);
`endif
        end else begin
          dl_cnt_nxt = dl_cnt_r + 2'd1;
        end
        dl1_nxt     = dl0_r;
        dl0_nxt     = append_byte_s;
        rcv_cnt_nxt = rcv_cnt_r + RCV_W'(1);
      end
    end else begin
      append_byte_s = 8'h00;
    end
  end

  // Parser registers and registered outputs; disable idles without error pulses.
  always_ff @(posedge sb_clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      lse_r        <= 8'h00;
      is_rsp_r     <= 1'b0;
      dl0_r        <= 8'h00;
      dl1_r        <= 8'h00;
      dl_cnt_r     <= 2'd0;
      rcv_cnt_r    <= '0;
      buf_r        <= '0;
      buf_cnt_r    <= '0;
      lt_valid_r   <= 1'b0;
      lt_lse_r     <= 8'h00;
      at_valid_r   <= 1'b0;
      at_is_rsp_r  <= 1'b0;
      at_len_r     <= '0;
      at_payload_r <= '0;
      proto_err_r  <= 1'b0;
      busy_r       <= 1'b0;
    end else if (!enable) begin
      state_r     <= ST_IDLE;
      lt_valid_r  <= 1'b0;
      at_valid_r  <= 1'b0;
      proto_err_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r      <= state_nxt;
      lse_r        <= lse_nxt;
      is_rsp_r     <= is_rsp_nxt;
      dl0_r        <= dl0_nxt;
      dl1_r        <= dl1_nxt;
      dl_cnt_r     <= dl_cnt_nxt;
      rcv_cnt_r    <= rcv_cnt_nxt;
      buf_r        <= buf_nxt;
      buf_cnt_r    <= buf_cnt_nxt;
      lt_valid_r   <= lt_valid_nxt;
      lt_lse_r     <= lt_lse_nxt;
      at_valid_r   <= at_valid_nxt;
      at_is_rsp_r  <= at_is_rsp_nxt;
      at_len_r     <= at_len_nxt;
      at_payload_r <= at_payload_nxt;
      proto_err_r  <= proto_err_nxt;
      busy_r       <= (state_nxt != ST_IDLE);
    end
  end

`ifdef SB_RX_CRC_CHECK_EN
  // CRC accumulator and mismatch pulse.
  always_ff @(posedge sb_clk) begin
    if (rst) begin
      crc_r     <= 16'hFFFF;
      crc_err_r <= 1'b0;
    end else if (!enable) begin
      crc_err_r <= 1'b0;
    end else begin
      crc_r     <= crc_nxt;
      crc_err_r <= crc_err_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_sb_transaction_rx.sv
module tb_sb_transaction_rx;

  localparam int MAX_BYTES = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         sbrx;
  logic         enable;
  logic         lt_valid;
  logic [7:0]   lt_lse;
  logic         at_valid;
  logic         at_is_rsp;
  logic [4:0]   at_len;
  logic [127:0] at_payload;
  logic         crc_err;
  logic         frame_err;
  logic         proto_err;
  logic         busy;

  int checks   = 0;
  int failures = 0;
  int n_lt = 0, n_at = 0, n_pr = 0, n_fr = 0, n_crc = 0;
  int b_lt, b_at, b_pr, b_fr, b_crc;
  logic [127:0] exp_pl;

  sb_transaction_rx #(.MAX_BYTES(MAX_BYTES), .SYNC_STG(2)) dut (
    .sb_clk     (clk),
    .rst        (rst),
    .sbrx       (sbrx),
    .enable     (enable),
    .lt_valid   (lt_valid),
    .lt_lse     (lt_lse),
    .at_valid   (at_valid),
    .at_is_rsp  (at_is_rsp),
    .at_len     (at_len),
    .at_payload (at_payload),
    .crc_err    (crc_err),
    .frame_err  (frame_err),
    .proto_err  (proto_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled on the falling edge.
  always @(negedge clk) begin
    if (lt_valid)  n_lt  <= n_lt + 1;
    if (at_valid)  n_at  <= n_at + 1;
    if (proto_err) n_pr  <= n_pr + 1;
    if (frame_err) n_fr  <= n_fr + 1;
    if (crc_err)   n_crc <= n_crc + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] tb_crc(input logic [15:0] c_in, input logic [7:0] b);
    logic [15:0] c;
    c = c_in ^ {b, 8'h00};
    for (int k = 0; k < 8; k++) c = c[15] ? ({c[14:0], 1'b0} ^ 16'h8005) : {c[14:0], 1'b0};
    return c;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    sbrx = b;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_bit = 1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop_bit);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  task automatic send_body(input logic [7:0] d);
    send_byte(d);
    if (d == 8'hFE) send_byte(8'hFE);
  endtask

  task automatic send_lt(input logic [7:0] lse, input logic [7:0] cmp);
    send_byte(8'hFE); send_byte(lse); send_byte(cmp);
  endtask

  task automatic send_at2(input logic [7:0] stx, input logic [7:0] p0, input logic [7:0] p1, input logic [15:0] flip);
    logic [15:0] c;
    c = tb_crc(tb_crc(tb_crc(16'hFFFF, stx), p0), p1) ^ flip;
    send_byte(8'hFE); send_byte(stx);
    send_body(p0); send_body(p1); send_body(c[7:0]); send_body(c[15:8]);
    send_byte(8'hFE); send_byte(8'h40);
  endtask

  task automatic snap();
    b_lt = n_lt; b_at = n_at; b_pr = n_pr; b_fr = n_fr; b_crc = n_crc;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; sbrx = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_lt_valid", lt_valid, 0);
    check("rst_lt_lse", lt_lse, 0);
    check("rst_at_valid", at_valid, 0);
    check("rst_at_is_rsp", at_is_rsp, 0);
    check("rst_at_len", at_len, 0);
    check("rst_at_payload", at_payload, 0);
    check("rst_crc_err", crc_err, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_proto_err", proto_err, 0);
    check("rst_busy", busy, 0);
    idle(4);

    // Good LT
    snap();
    send_lt(8'h20, 8'hDF);
    idle(12);
    check("lt_pulse", n_lt - b_lt, 1);
    check("lt_lse", lt_lse, 8'h20);
    check("lt_busy", busy, 0);
    check("lt_no_proto", n_pr - b_pr, 0);

    // LT with bad complement
    snap();
    send_lt(8'h20, 8'hDE);
    idle(12);
    check("ltbad_proto", n_pr - b_pr, 1);
    check("ltbad_no_lt", n_lt - b_lt, 0);
    check("ltbad_busy", busy, 0);

    snap();
    send_lt(8'h5A, 8'hA5);
    idle(12);
    check("lt2_pulse", n_lt - b_lt, 1);
    check("lt2_lse", lt_lse, 8'h5A);

    // AT command, valid CRC
    snap();
    send_at2(8'h05, 8'h11, 8'h22, 16'h0000);
    idle(12);
    exp_pl = '0; exp_pl[15:0] = 16'h2211;
    check("at_pulse", n_at - b_at, 1);
    check("at_is_rsp", at_is_rsp, 0);
    check("at_len", at_len, 2);
    check("at_payload", at_payload, exp_pl);
    check("at_crc_ok", n_crc - b_crc, 0);
    check("at_no_proto", n_pr - b_pr, 0);
    check("at_lt_lse_hold", lt_lse, 8'h5A);
    check("at_busy", busy, 0);

    // AT response with stuffed DLE in payload
    snap();
    send_at2(8'h04, 8'hFE, 8'h33, 16'h0000);
    idle(12);
    exp_pl = '0; exp_pl[15:0] = 16'h33FE;
    check("stuff_pulse", n_at - b_at, 1);
    check("stuff_is_rsp", at_is_rsp, 1);
    check("stuff_len", at_len, 2);
    check("stuff_payload", at_payload, exp_pl);
    check("stuff_crc_ok", n_crc - b_crc, 0);

    // One corrupted CRC bit
    snap();
    send_at2(8'h05, 8'h11, 8'h22, 16'h0001);
    idle(12);
    check("crcbad_pulse", n_at - b_at, 1);
`ifdef SB_RX_CRC_CHECK_EN
    check("crcbad_crc_err", n_crc - b_crc, 1);
`else
    check("crcbad_crc_err", n_crc - b_crc, 0);
`endif

    // Framing error mid-AT, then a good LT
    snap();
    send_byte(8'hFE); send_byte(8'h05); send_byte(8'h11);
    idle(4);
    check("frm_busy_mid", busy, 1);
    send_byte(8'h22, 1'b0);
    idle(12);
    check("frm_pulse", n_fr - b_fr, 1);
    check("frm_busy", busy, 0);
    check("frm_no_at", n_at - b_at, 0);
    send_lt(8'h3C, 8'hC3);
    idle(12);
    check("frm_lt_pulse", n_lt - b_lt, 1);
    check("frm_lt_lse", lt_lse, 8'h3C);

    // Fewer than two bytes before ETX
    snap();
    send_byte(8'hFE); send_byte(8'h05); send_byte(8'h11); send_byte(8'hFE); send_byte(8'h40);
    idle(12);
    check("short_proto", n_pr - b_pr, 1);
    check("short_no_at", n_at - b_at, 0);

    // Overflow: MAX_BYTES+3 body bytes
    snap();
    send_byte(8'hFE); send_byte(8'h05);
    for (int i = 0; i < MAX_BYTES + 3; i++) send_byte(8'(i + 1));
    idle(12);
    check("ovf_proto", n_pr - b_pr, 1);
    check("ovf_no_at", n_at - b_at, 0);
    check("ovf_busy", busy, 0);

    // Enable drop mid-AT
    snap();
    send_byte(8'hFE); send_byte(8'h05); send_byte(8'h11);
    enable = 1'b0;
    idle(4);
    check("en_busy", busy, 0);
    enable = 1'b1;
    idle(4);
    send_lt(8'h7E, 8'h81);
    idle(12);
    check("en_lt_pulse", n_lt - b_lt, 1);
    check("en_lt_lse", lt_lse, 8'h7E);
    check("en_no_err", (n_pr - b_pr) + (n_fr - b_fr), 0);
    check("en_no_at", n_at - b_at, 0);

    // Reset mid-AT
    snap();
    send_byte(8'hFE); send_byte(8'h05); send_byte(8'h11); send_byte(8'h22);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(12);
    check("rstm_no_at", n_at - b_at, 0);
    check("rstm_at_len", at_len, 0);
    check("rstm_at_payload", at_payload, 0);
    check("rstm_at_is_rsp", at_is_rsp, 0);
    check("rstm_lt_lse", lt_lse, 0);
    check("rstm_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
